tape_bit_writer: RTL and testbench

TAPE_BIT_WRITER -- requirements
Module: tape_bit_writer

---
 rtl/tape_bit_writer.sv | 167 ++++++++++++++++
 tb/tb_tape_bit_writer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tape_bit_writer.sv
// tape_bit_writer: generates a pilot/sync/data/end tape waveform from a byte stream
module tape_bit_writer #(
  parameter int CLK_FREQ     = 27000000,
  parameter int TICKS_PILOT  = 16724,
  parameter int PILOT_HALVES = 3224,
  parameter int TICKS_SYNC1  = 5145,
  parameter int TICKS_SYNC2  = 5670,
  parameter int TICKS_0      = 3600,
  parameter int TICKS_1      = 7200,
  parameter int TICKS_END    = 5145,
  parameter int TICKS_PAUSE  = 27000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       aud,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic       edge_led
);
  localparam logic [31:0] TPM = 32'(TICKS_PILOT - 1);
  localparam logic [31:0] PHM = 32'(PILOT_HALVES - 1);
  localparam logic [31:0] S1M = 32'(TICKS_SYNC1 - 1);
  localparam logic [31:0] S2M = 32'(TICKS_SYNC2 - 1);
  localparam logic [31:0] T0M = 32'(TICKS_0 - 1);
  localparam logic [31:0] T1M = 32'(TICKS_1 - 1);
  localparam logic [31:0] TEM = 32'(TICKS_END - 1);
  localparam logic [31:0] TAM = 32'(TICKS_PAUSE - 1);
  typedef enum logic [2:0] {IDLE, PILOT, SYNC1, SYNC2, DATA, END, PAUSE} state_t;
  state_t state, state_n;
  logic [31:0] cnt, cnt_n, half, half_n;
  logic [7:0] shifter, shifter_n, hold_data, hold_data_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic low, low_n, cur_last, cur_last_n, hold_valid, hold_valid_n, hold_last, hold_last_n;
  logic last_acc, last_acc_n, aud_n, done_n, underrun_n, edge_led_n;
  logic expired, accept, need_load, to_end, load;
  assign busy = state != IDLE;
  assign data_ready = busy & ~hold_valid & ~last_acc;
  assign accept = data_valid & data_ready;
  assign expired = cnt == 32'd0;
  always_comb begin
    state_n = state;
    cnt_n = expired ? cnt : cnt - 32'd1;
    half_n = half;
    shifter_n = shifter;
    bit_idx_n = bit_idx;
    low_n = low;
    cur_last_n = cur_last;
    aud_n = aud;
    done_n = 1'b0;
    underrun_n = 1'b0;
    need_load = 1'b0;
    to_end = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = PILOT;
        cnt_n = TPM;
        aud_n = 1'b1;
        half_n = 32'd0;
      end
      PILOT: if (expired) begin
        if (half == PHM) begin
          state_n = SYNC1;
          cnt_n = S1M;
          aud_n = 1'b1;
        end else begin
          half_n = half + 32'd1;
          aud_n = ~aud;
          cnt_n = TPM;
        end
      end
      SYNC1: if (expired) begin
        state_n = SYNC2;
        cnt_n = S2M;
        aud_n = 1'b0;
      end
      SYNC2: need_load = expired;
      DATA: if (expired) begin
        if (!low) begin
          low_n = 1'b1;
          aud_n = 1'b0;
          cnt_n = shifter[7] ? T1M : T0M;
        end else if (bit_idx != 3'd0) begin
          bit_idx_n = bit_idx - 3'd1;
          shifter_n = {shifter[6:0], 1'b0};
          low_n = 1'b0;
          aud_n = 1'b1;
          cnt_n = shifter[6] ? T1M : T0M;
        end else begin
          to_end = cur_last;
          need_load = ~cur_last;
        end
      end
      END: if (expired) begin
        state_n = PAUSE;
        cnt_n = TAM;
        aud_n = 1'b0;
      end
      PAUSE: if (expired) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (need_load && hold_valid) begin
      load = 1'b1;
      state_n = DATA;
      shifter_n = hold_data;
      cur_last_n = hold_last;
      bit_idx_n = 3'd7;
      low_n = 1'b0;
      aud_n = 1'b1;
      cnt_n = hold_data[7] ? T1M : T0M;
    end else if (need_load || to_end) begin
      underrun_n = need_load;
      state_n = END;
      aud_n = 1'b1;
      cnt_n = TEM;
    end
    hold_valid_n = (state == IDLE) ? 1'b0 : accept | (hold_valid & ~load);
    hold_data_n = accept ? data_in : hold_data;
    hold_last_n = accept ? data_last : hold_last;
    last_acc_n = (state == IDLE) ? 1'b0 : last_acc | (accept & data_last);
    edge_led_n = edge_led ^ (aud_n & ~aud);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      half <= '0;
      shifter <= '0;
      bit_idx <= '0;
      low <= 1'b0;
      cur_last <= 1'b0;
      hold_valid <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
      last_acc <= 1'b0;
      aud <= 1'b0;
      done <= 1'b0;
      underrun <= 1'b0;
      edge_led <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      half <= half_n;
      shifter <= shifter_n;
      bit_idx <= bit_idx_n;
      low <= low_n;
      cur_last <= cur_last_n;
      hold_valid <= hold_valid_n;
      hold_data <= hold_data_n;
      hold_last <= hold_last_n;
      last_acc <= last_acc_n;
      aud <= aud_n;
      done <= done_n;
      underrun <= underrun_n;
      edge_led <= edge_led_n;
    end
  end
endmodule

// File: tb/tb_tape_bit_writer.sv
// tb_tape_bit_writer: random byte blocks checked cycle by cycle against a waveform queue model
module tb_tape_bit_writer;
  localparam int TP = 8, PH = 4, S1 = 3, S2 = 4, T0 = 2, T1 = 4, TE = 3, TA = 5;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, data_valid = 1'b0, data_last = 1'b0;
  logic [7:0] data_in = '0;
  logic data_ready, aud, busy, done, underrun, edge_led;
  int checks = 0, fails = 0, end_idx = 0, busy_cnt = 0;
  bit wave[$];
  bit abort = 0, last_flag = 0, led_exp = 0, prev_a = 0;
  tape_bit_writer #(
    .TICKS_PILOT(TP), .PILOT_HALVES(PH), .TICKS_SYNC1(S1), .TICKS_SYNC2(S2),
    .TICKS_0(T0), .TICKS_1(T1), .TICKS_END(TE), .TICKS_PAUSE(TA)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .data_ready(data_ready), .aud(aud), .busy(busy), .done(done),
    .underrun(underrun), .edge_led(edge_led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic build(input int n, input logic [7:0] bytes [4]);
    wave.delete();
    for (int h = 0; h < PH; h++) repeat (TP) wave.push_back(h % 2 == 0);
    repeat (S1) wave.push_back(1);
    repeat (S2) wave.push_back(0);
    for (int k = 0; k < n; k++)
      for (int j = 7; j >= 0; j--) begin
        repeat (bytes[k][j] ? T1 : T0) wave.push_back(1);
        repeat (bytes[k][j] ? T1 : T0) wave.push_back(0);
      end
    end_idx = wave.size();
    repeat (TE) wave.push_back(1);
    repeat (TA) wave.push_back(0);
  endtask
  task automatic drive(input int n, input logic [7:0] bytes [4]);
    int waited;
    last_flag = 0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (abort) break;
      data_valid = 1'b1;
      data_in = bytes[k];
      data_last = (k == n - 1);
      waited = 0;
      while (!data_ready && !abort && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (abort) break;
      if (waited >= 300) begin
        chk("ready_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
      if (data_last) last_flag = 1;
      data_valid = 1'b0;
    end
    data_valid = 1'b0;
  endtask
  task automatic watch(input int n, input bit glitch, input int abort_at);
    bit ea;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i <= wave.size(); i++) begin
      if (i == abort_at) begin
        abort = 1;
        reset = 1'b1;
        @(negedge clk);
        led_exp = 0;
        chk("rst_aud", aud, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", data_ready, 0);
        chk("rst_led", edge_led, 0);
        return;
      end
      ea = (i < wave.size()) ? wave[i] : 1'b0;
      if (ea && !prev_a) led_exp = ~led_exp;
      prev_a = ea;
      chk("aud", aud, ea);
      chk("busy", busy, i < wave.size());
      chk("done", done, i == wave.size());
      chk("underrun", underrun, n == 0 && i == end_idx);
      chk("edge_led", edge_led, led_exp);
      if (last_flag) chk("ready_after_last", data_ready, 0);
      busy_cnt += busy;
      start = glitch && i == 10;
      @(negedge clk);
    end
    chk("done_pulse_end", done, 0);
  endtask
  task automatic run_block(input int n, input logic [7:0] bytes [4], input bit glitch, input int abort_at);
    build(n, bytes);
    abort = 0;
    prev_a = 0;
    fork
      drive(n, bytes);
      watch(n, glitch, abort_at);
    join
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] b [4];
    repeat (3) @(negedge clk);
    chk("init_aud", aud, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_underrun", underrun, 0);
    chk("init_led", edge_led, 0);
    chk("init_ready", data_ready, 0);
    b = '{8'hA5, 8'h00, 8'h00, 8'h00};
    build(1, b);
    chk("model_len_a5", wave.size(), 95);
    chk("model_first_bit_hi", wave[42], 1);
    chk("model_first_bit_lo", wave[43], 0);
    run_block(1, b, 0, -1);
    chk("busy_len_a5", busy_cnt, 95);
    run_block(0, b, 0, -1);
    chk("busy_len_underrun", busy_cnt, 47);
    b = '{8'h00, 8'hFF, 8'h00, 8'h00};
    run_block(2, b, 0, -1);
    chk("busy_len_00ff", busy_cnt, 143);
    b = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_block(1, b, 1, -1);
    chk("busy_len_glitch", busy_cnt, 95);
    b = '{8'h3C, 8'h81, 8'h00, 8'h00};
    run_block(2, b, 0, 50);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
      run_block($urandom_range(1, 4), b, 1'($urandom), -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
